// File: rtl/button_ctrl_pkg.sv
// Shared types, channel indices and width helper for the button controller.
package button_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } stretch_state_e;

    localparam int unsigned NUM_CH   = 2;
    localparam int unsigned CH_MAGIC = 0;
    localparam int unsigned CH_PAUSE = 1;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_ctrl_if.sv
// Signal bundle between the frame/keyboard/pin sources and the button controller.
interface button_ctrl_if;

    logic n_int;
    logic n_int_next;
    logic btn_magic_n;
    logic btn_pause_n;
    logic kbd_magic;
    logic kbd_pause;
    logic magic_button;
    logic pause_button;
    logic reboot_req;

    modport master (
        output n_int, n_int_next, btn_magic_n, btn_pause_n, kbd_magic, kbd_pause,
        input  magic_button, pause_button, reboot_req
    );

    modport slave (
        input  n_int, n_int_next, btn_magic_n, btn_pause_n, kbd_magic, kbd_pause,
        output magic_button, pause_button, reboot_req
    );

endinterface

// File: rtl/button_ctrl_debounce.sv
// Two-flop synchronizer plus tick-sampled stable counter for one active-low pin.
module button_ctrl_debounce
    import button_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = 16
) (
    input  logic clk28,
    input  logic rst_n,
    input  logic tick_i,
    input  logic pin_n_i,
    output logic pressed_o
);

    localparam int unsigned     DW     = cnt_width(DEBOUNCE_MS - 1);
    localparam logic [DW-1:0]   D_LAST = DW'(DEBOUNCE_MS - 1);

    logic          sync1_q, sync2_q;
    logic          state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;

    // Only tick-spaced samples count; any agreeing sample restarts the run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick_i) begin
            if (sync2_q != state_q) begin
                if (cnt_q == D_LAST) begin
                    state_d = sync2_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ~pin_n_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed_o = state_q;

endmodule

// File: rtl/button_ctrl.sv
// Magic/pause button conditioning: debounce, frame-based output stretch and
// magic long-press reboot request.
module button_ctrl
    import button_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE       = 28000,
    parameter int unsigned DEBOUNCE_MS    = 16,
    parameter int unsigned LONGPRESS_MS   = 2000,
    parameter int unsigned STRETCH_FRAMES = 2
) (
    input logic         clk28,
    input logic         rst_n,
    button_ctrl_if.slave bus
);

    localparam int unsigned   PW      = cnt_width(PRESCALE - 1);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
    localparam int unsigned   FW      = cnt_width(STRETCH_FRAMES);
    localparam logic [FW-1:0] F_LOAD  = FW'(STRETCH_FRAMES);
    localparam int unsigned   LW      = cnt_width(LONGPRESS_MS);
    localparam logic [LW-1:0] LP_MAX  = LW'(LONGPRESS_MS);
    localparam logic [LW-1:0] LP_LAST = LW'(LONGPRESS_MS - 1);

    logic [PW-1:0]     ps_q, ps_d;
    logic              tick;
    logic              frame_edge;
    logic [NUM_CH-1:0] pin_n, kbd, deb, req, out;
    logic [LW-1:0]     lp_q, lp_d;
    logic              reboot_q, reboot_d;

    assign tick       = (ps_q == PS_LAST);
    assign ps_d       = tick ? '0 : ps_q + PW'(1);
    assign frame_edge = bus.n_int & ~bus.n_int_next;

    assign pin_n[CH_MAGIC] = bus.btn_magic_n;
    assign pin_n[CH_PAUSE] = bus.btn_pause_n;
    assign kbd[CH_MAGIC]   = bus.kbd_magic;
    assign kbd[CH_PAUSE]   = bus.kbd_pause;
    assign req             = deb | kbd;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        stretch_state_e st_q;
        logic [FW-1:0]  fcnt_q;
        logic           req_q;
        logic           out_q;
        logic           rise;

        button_ctrl_debounce #(
            .DEBOUNCE_MS (DEBOUNCE_MS)
        ) u_debounce (
            .clk28     (clk28),
            .rst_n     (rst_n),
            .tick_i    (tick),
            .pin_n_i   (pin_n[g]),
            .pressed_o (deb[g])
        );

        assign rise = req[g] & ~req_q;

        // A reload on a fresh press takes priority over a same-cycle frame edge.
        always_ff @(posedge clk28 or negedge rst_n) begin
            if (!rst_n) begin
                st_q   <= ST_IDLE;
                fcnt_q <= '0;
                req_q  <= 1'b0;
                out_q  <= 1'b0;
            end else begin
                req_q <= req[g];
                case (st_q)
                    ST_IDLE: begin
                        if (rise) begin
                            st_q   <= ST_HOLD;
                            out_q  <= 1'b1;
                            fcnt_q <= F_LOAD;
                        end
                    end
                    ST_HOLD: begin
                        if (rise) begin
                            fcnt_q <= F_LOAD;
                        end else if (!req[g] && fcnt_q == '0) begin
                            st_q  <= ST_IDLE;
                            out_q <= 1'b0;
                        end else if (frame_edge && fcnt_q != '0) begin
                            fcnt_q <= fcnt_q - FW'(1);
                        end
                    end
                    default: begin
                        st_q  <= ST_IDLE;
                        out_q <= 1'b0;
                    end
                endcase
            end
        end

        assign out[g] = out_q;
    end

    // Only the debounced pin counts; the pulse fires on the step into saturation.
    always_comb begin
        lp_d     = lp_q;
        reboot_d = 1'b0;
        if (!deb[CH_MAGIC]) begin
            lp_d = '0;
        end else if (tick && lp_q != LP_MAX) begin
            lp_d     = lp_q + LW'(1);
            reboot_d = (lp_q == LP_LAST);
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            ps_q     <= '0;
            lp_q     <= '0;
            reboot_q <= 1'b0;
        end else begin
            ps_q     <= ps_d;
            lp_q     <= lp_d;
            reboot_q <= reboot_d;
        end
    end

    assign bus.magic_button = out[CH_MAGIC];
    assign bus.pause_button = out[CH_PAUSE];
    assign bus.reboot_req   = reboot_q;

endmodule
